alu_writeback: RTL and testbench

Result-side partner of the EX-stage ALU: accepts each retired ALU instruction together with its 32-bit result and writes it to a register-file write port. A small in-order FIFO absorbs cycles where the register-file port is busy, for example when another VLIW lane holds the arbitration. While a result waits in the FIFO, that value can be forwarded to operand read by lookup ports.

---
 rtl/alu_writeback.sv | 130 +++++++++++++
 tb/tb_alu_writeback.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// alu_writeback: in-order result FIFO between the EX-stage ALU and one register-file write port.
// Optional macro WB_BYPASS_EN adds two combinational forwarding lookup ports over the queued results.
package alu_wb_pkg;
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] funct;
  } instruction_t;
endpackage

module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int REG_AW = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  instruction_t                 inst_in,
  input  logic [31:0]                  result_in,
  output logic                         rf_wr_en,
  input  logic                         rf_wr_ready,
  output logic [REG_AW-1:0]            rf_wr_addr,
  output logic [31:0]                  rf_wr_data,
  output logic [$clog2(DEPTH+1)-1:0]   pending
`ifdef WB_BYPASS_EN
  , input  logic [REG_AW-1:0]          fwd_addr_a
  , input  logic [REG_AW-1:0]          fwd_addr_b
  , output logic                       fwd_hit_a
  , output logic                       fwd_hit_b
  , output logic [31:0]                fwd_data_a
  , output logic [31:0]                fwd_data_b
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][REG_AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][31:0]       data_q, data_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [REG_AW-1:0]            in_rd;
  logic                         push, store, pop, empty;
  logic                         unused_inst;

  assign in_rd       = inst_in.rd;
  assign unused_inst = ^inst_in;

  // Ready and write request come from registered occupancy only.
  assign empty      = (cnt_q == '0);
  assign in_ready   = (cnt_q != FULL);
  assign rf_wr_en   = !empty;
  assign rf_wr_addr = empty ? '0 : addr_q[rd_ptr_q];
  assign rf_wr_data = empty ? '0 : data_q[rd_ptr_q];
  assign pending    = cnt_q;

  always_comb begin
    push     = in_valid && in_ready;
    store    = push && (in_rd != '0);   // x0 writes complete the handshake but are dropped
    pop      = rf_wr_en && rf_wr_ready;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (store) begin
      addr_d[wr_ptr_q] = in_rd;
      data_d[wr_ptr_q] = result_in;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({store, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef WB_BYPASS_EN
  logic [1:0][REG_AW-1:0] fa;
  logic [1:0]             fh;
  logic [1:0][31:0]       fd;
  logic [PW-1:0]          idx;

  assign fa = {fwd_addr_b, fwd_addr_a};

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fh  = '0;
    fd  = '0;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr_q + PW'(k);
        if ((CW'(k) < cnt_q) && (fa[p] != '0) && (addr_q[idx] == fa[p])) begin
          fh[p] = 1'b1;
          fd[p] = data_q[idx];
        end
      end
    end
  end

  assign fwd_hit_a  = fh[0];
  assign fwd_hit_b  = fh[1];
  assign fwd_data_a = fd[0];
  assign fwd_data_b = fd[1];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed vector table, hand sequences, and a queue-model random run.
module tb_alu_writeback;
  import alu_wb_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  instruction_t inst_in = '0;
  logic [31:0]  result_in = '0;
  logic         rf_wr_en;
  logic         rf_wr_ready = 1'b0;
  logic [4:0]   rf_wr_addr;
  logic [31:0]  rf_wr_data;
  logic [2:0]   pending;
`ifdef WB_BYPASS_EN
  logic [4:0]   fa = '0, fb = '0;
  logic         fwd_hit_a, fwd_hit_b;
  logic [31:0]  fwd_data_a, fwd_data_b;
`endif

  int total = 0;
  int bad   = 0;

  alu_writeback #(.DEPTH(DEPTH), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_in(inst_in), .result_in(result_in), .rf_wr_en(rf_wr_en),
    .rf_wr_ready(rf_wr_ready), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .pending(pending)
`ifdef WB_BYPASS_EN
    , .fwd_addr_a(fa), .fwd_addr_b(fb), .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b)
    , .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [31:0] d;
    bit          r;
    bit          en;
    logic [4:0]  a;
    logic [31:0] ed;
    int          pend;
    bit          irdy;
  } vec_t;
  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_model();
    bit ne;
    ne = (q.size() != 0);
    check("rf_wr_en", rf_wr_en, ne);
    check("rf_wr_addr", rf_wr_addr, ne ? q[0].rd : 5'd0);
    check("rf_wr_data", rf_wr_data, ne ? q[0].d : 32'd0);
    check("pending", pending, q.size());
    check("in_ready", in_ready, q.size() != DEPTH);
`ifdef WB_BYPASS_EN
    begin
      logic hit_a = 1'b0, hit_b = 1'b0;
      logic [31:0] da = '0, db = '0;
      foreach (q[i]) begin
        if (fa != 0 && q[i].rd == fa) begin hit_a = 1'b1; da = q[i].d; end
        if (fb != 0 && q[i].rd == fb) begin hit_b = 1'b1; db = q[i].d; end
      end
      check("fwd_hit_a", fwd_hit_a, hit_a);
      check("fwd_data_a", fwd_data_a, da);
      check("fwd_hit_b", fwd_hit_b, hit_b);
      check("fwd_data_b", fwd_data_b, db);
    end
`endif
  endtask

  // One clock: drive, compare against the queue model, then advance the model at the edge.
  task automatic mstep(input bit v, input logic [4:0] rd, input logic [31:0] d, input bit r);
    bit push, pop;
    @(negedge clk);
    in_valid = v; inst_in = '0; inst_in.rd = rd; result_in = d; rf_wr_ready = r;
    #1 cmp_model();
    push = v && (q.size() != DEPTH);
    pop  = (q.size() != 0) && r;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push && rd != 0) q.push_back('{rd, d});
  endtask

  initial begin
    tbl[0]  = '{1, 3, 32'hDEADBEEF, 1, 0, 0, 0,            0, 1};
    tbl[1]  = '{0, 0, 0,             1, 1, 3, 32'hDEADBEEF, 1, 1};
    tbl[2]  = '{1, 0, 32'h1234,      1, 0, 0, 0,            0, 1};
    tbl[3]  = '{0, 0, 0,             1, 0, 0, 0,            0, 1};
    tbl[4]  = '{1, 1, 32'h101,       0, 0, 0, 0,            0, 1};
    tbl[5]  = '{1, 2, 32'h102,       0, 1, 1, 32'h101,      1, 1};
    tbl[6]  = '{1, 3, 32'h103,       0, 1, 1, 32'h101,      2, 1};
    tbl[7]  = '{1, 4, 32'h104,       0, 1, 1, 32'h101,      3, 1};
    tbl[8]  = '{1, 5, 32'h105,       0, 1, 1, 32'h101,      4, 0};
    tbl[9]  = '{1, 5, 32'h105,       1, 1, 1, 32'h101,      4, 0};
    tbl[10] = '{1, 5, 32'h105,       1, 1, 2, 32'h102,      3, 1};
    tbl[11] = '{0, 0, 0,             1, 1, 3, 32'h103,      3, 1};
    tbl[12] = '{0, 0, 0,             1, 1, 4, 32'h104,      2, 1};
    tbl[13] = '{0, 0, 0,             1, 1, 5, 32'h105,      1, 1};
    tbl[14] = '{0, 0, 0,             1, 0, 0, 0,            0, 1};

    // Reset state
    #12;
    check("rst_en", rf_wr_en, 1'b0);
    check("rst_addr", rf_wr_addr, 5'd0);
    check("rst_data", rf_wr_data, 32'd0);
    check("rst_pending", pending, 3'd0);
    check("rst_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b1;

    // Directed vectors: single write, x0 drop, fill/backpressure/drain order
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; inst_in = '0; inst_in.rd = tbl[i].rd;
      result_in = tbl[i].d; rf_wr_ready = tbl[i].r;
      #1;
      check($sformatf("v%0d_en", i), rf_wr_en, tbl[i].en);
      check($sformatf("v%0d_addr", i), rf_wr_addr, tbl[i].a);
      check($sformatf("v%0d_data", i), rf_wr_data, tbl[i].ed);
      check($sformatf("v%0d_pend", i), pending, tbl[i].pend);
      check($sformatf("v%0d_rdy", i), in_ready, tbl[i].irdy);
    end

`ifdef WB_BYPASS_EN
    // Youngest-match forwarding and x0 lookup
    mstep(1, 7, 32'h11, 0);
    mstep(1, 7, 32'h22, 0);
    fa = 5'd7; fb = 5'd0;
    mstep(0, 0, 0, 0);
    #1;
    check("fwd_a_hit", fwd_hit_a, 1'b1);
    check("fwd_a_data", fwd_data_a, 32'h22);
    check("fwd_b_hit", fwd_hit_b, 1'b0);
    check("fwd_b_data", fwd_data_b, 32'h0);
    for (int i = 0; i < 3; i++) mstep(0, 0, 0, 1);
`endif

    // Reset mid-drain discards queued results
    mstep(1, 9, 32'hA1, 0);
    mstep(1, 10, 32'hA2, 0);
    mstep(1, 11, 32'hA3, 0);
    mstep(0, 0, 0, 1);
    @(negedge clk);
    in_valid = 1'b0; rf_wr_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_en", rf_wr_en, 1'b0);
    check("mid_rst_addr", rf_wr_addr, 5'd0);
    check("mid_rst_data", rf_wr_data, 32'd0);
    check("mid_rst_pending", pending, 3'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    q.delete();
    @(negedge clk); rst = 1'b1;
    mstep(1, 2, 32'h5, 1);
    mstep(0, 0, 0, 1);
    mstep(0, 0, 0, 1);
    mstep(0, 0, 0, 1);

    // Random traffic; ready toggles for the first 16 cycles
    for (int i = 0; i < 400; i++) begin
      bit v, r;
      logic [4:0] rd;
`ifdef WB_BYPASS_EN
      fa = 5'($urandom_range(0, 7));
      fb = 5'($urandom_range(0, 7));
`endif
      v  = ($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 7));
      r  = (i < 16) ? (i % 2 == 0) : ($urandom_range(0, 2) != 0);
      mstep(v, rd, $urandom, r);
    end
    for (int i = 0; i < DEPTH + 2; i++) mstep(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
